// File: rtl/hs_df.sv
// rtl/hs_df.sv - per-lane half subtractor with registered copy and saturating borrow counter
module hs_df #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] s_q,
  output logic [WIDTH-1:0] b_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Lanes are bitwise and never chain a borrow into a neighbour.
  assign s = x ^ y;
  assign B = ~x & y;

  logic any_borrow;
  assign any_borrow = |B;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q        <= '0;
      b_q        <= '0;
      out_valid  <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= s;
        b_q <= B;
      end
      // Clear wins over a coincident borrow sample; counter sticks at its maximum.
      if (cnt_clr) begin
        borrow_cnt <= '0;
      end else if (in_valid && any_borrow && (borrow_cnt != CNT_MAX)) begin
        borrow_cnt <= borrow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hs_df.sv
// tb/tb_hs_df.sv - scoreboard bench for hs_df against an arithmetic reference model
module tb_hs_df;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] x = '0;
  logic [WIDTH-1:0] y = '0;
  logic             in_valid = 1'b0;
  logic             cnt_clr = 1'b0;
  logic [WIDTH-1:0] s, B, s_q, b_q;
  logic             out_valid;
  logic [CNT_W-1:0] borrow_cnt;

  hs_df #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .s(s), .B(B), .s_q(s_q), .b_q(b_q), .out_valid(out_valid), .borrow_cnt(borrow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] sq;
    logic [WIDTH-1:0] bq;
    int               cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [WIDTH-1:0] m_sq = '0;
  logic [WIDTH-1:0] m_bq = '0;
  int               m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Difference and borrow from integer subtraction of each lane's bits.
  function automatic void ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  output logic [WIDTH-1:0] d, output logic [WIDTH-1:0] br);
    for (int i = 0; i < WIDTH; i++) begin
      int diff;
      diff  = int'(a[i]) - int'(b[i]);
      d[i]  = (diff != 0);
      br[i] = (diff < 0);
    end
  endfunction

  task automatic check_comb();
    logic [WIDTH-1:0] d, br;
    ref_sub(x, y, d, br);
    chk("s", 32'(s), 32'(d));
    chk("B", 32'(B), 32'(br));
  endtask

  task automatic check_regs_zero(input string tag);
    chk({tag, ".s_q"}, 32'(s_q), 0);
    chk({tag, ".b_q"}, 32'(b_q), 0);
    chk({tag, ".out_valid"}, 32'(out_valid), 0);
    chk({tag, ".borrow_cnt"}, 32'(borrow_cnt), 0);
  endtask

  task automatic drive(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                       input logic v, input logic clr);
    logic [WIDTH-1:0] d, br;
    exp_t e;
    @(posedge clk);
    #2;
    x = xv; y = yv; in_valid = v; cnt_clr = clr;
    ref_sub(xv, yv, d, br);
    if (clr) m_cnt = 0;
    else if (v && (br != 0)) m_cnt = (m_cnt < CNT_SAT) ? m_cnt + 1 : CNT_SAT;
    if (v) begin
      m_sq = d;
      m_bq = br;
    end
    e.valid = v; e.sq = m_sq; e.bq = m_bq; e.cnt = m_cnt;
    exp_q.push_back(e);
    #1;
    check_comb();
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0; cnt_clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check_regs_zero("async_rst");
    exp_q.delete();
    m_sq = '0; m_bq = '0; m_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      chk("s_q", 32'(s_q), 32'(e.sq));
      chk("b_q", 32'(b_q), 32'(e.bq));
      chk("borrow_cnt", 32'(borrow_cnt), 32'(e.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] pat_x;
    logic [WIDTH-1:0] pat_y;
    // Single-lane truth table while held in reset.
    pat_x = 4'b0011; pat_y = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      x = {3'b000, pat_x[k]}; y = {3'b000, pat_y[k]};
      #2;
      check_comb();
      check_regs_zero("in_rst");
      #(2 * k + 2);
    end
    x = 4'b0101; y = 4'b0011;
    #1;
    chk("lane_s", 32'(s), 32'(4'b0110));
    chk("lane_B", 32'(B), 32'(4'b0010));
    for (int k = 0; k < 8; k++) begin
      x = WIDTH'($urandom); y = WIDTH'($urandom);
      #3;
      check_comb();
      check_regs_zero("in_rst");
    end
    @(negedge clk);
    rst_n = 1'b1;

    drive(4'b0000, 4'b0001, 1'b1, 1'b0);
    drive(4'b1111, 4'b0000, 1'b0, 1'b0);
    drive(4'b0110, 4'b1001, 1'b0, 1'b0);

    async_reset();
    for (int k = 0; k < 5; k++) drive(4'b0000, 4'b0001, 1'b1, 1'b0);

    async_reset();
    drive(4'b0000, 4'b0001, 1'b1, 1'b0);
    drive(4'b0000, 4'b0001, 1'b1, 1'b0);
    drive(4'b0000, 4'b0001, 1'b1, 1'b1);
    drive(4'b1010, 4'b1010, 1'b1, 1'b0);

    for (int k = 0; k < 300; k++) begin
      drive(WIDTH'($urandom), WIDTH'($urandom), 1'(($urandom_range(0, 3)) != 0),
            1'($urandom_range(0, 15) == 0));
      if (k == 150) async_reset();
    end
    drive(4'b0000, 4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hs_df.md
Name: hs_df

Overview:
- Half-subtractor datapath block with dataflow (combinational) outputs `s` (difference) and `B` (borrow) for x − y.
- Adds a one-cycle registered copy of the same results with a valid flag.
- Adds a saturating borrow-event counter.
- Used as a leaf arithmetic primitive; the combinational path feeds local logic, and the registered path feeds pipelined consumers.

Parameters:
- WIDTH, 1, number of independent 1-bit half-subtractor lanes (lane i uses x[i], y[i]); minimum 1.
- CNT_W, 8, width of the borrow-event counter; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- x  input  WIDTH  minuend bits.
- y  input  WIDTH  subtrahend bits.
- in_valid  input  1  qualifies x/y for the registered path and counter.
- cnt_clr  input  1  synchronous clear of borrow_cnt.
- s  output  WIDTH  combinational difference, s[i] = x[i] XOR y[i].
- B  output  WIDTH  combinational borrow, B[i] = (NOT x[i]) AND y[i].
- s_q  output  WIDTH  registered difference.
- b_q  output  WIDTH  registered borrow.
- out_valid  output  1  registered path holds a result captured on the previous edge.
- borrow_cnt  output  CNT_W  count of accepted samples with any borrow lane set.

Behaviour:
- Reset is asynchronous and active-low, on rst_n. While rst_n=0: s_q=0, b_q=0, out_valid=0, borrow_cnt=0.
- s and B are pure combinational functions of x and y. They are independent of clk, rst_n and in_valid, and are valid during reset. No latch, no delay element. Truth table per lane (x,y -> s,B): 00->0,0; 01->1,1; 10->1,0; 11->0,0.
- Registered path, 1-cycle latency: on a rising clk edge with in_valid=1, s_q<=s, b_q<=B, out_valid<=1.
- On an edge with in_valid=0: out_valid<=0, and s_q/b_q hold their previous values.
- Counter: on an edge with in_valid=1 and |B = 1, borrow_cnt increments by 1.
- Counter saturates at 2^CNT_W − 1; no wrap-around.
- cnt_clr=1 on an edge forces borrow_cnt to 0. cnt_clr has priority over a simultaneous increment, so that sample is not counted.
- Reset mid-operation: all registers clear immediately, independent of clk. The first edge after rst_n rises behaves like a normal edge.
- No X propagation from an unused lane: lanes are fully independent. There is no borrow chaining between lanes.

Test Plan:
- WIDTH=1: apply x,y = 00, 01, 10, 11, changing at t=0, 2, 6, 12 ns without any clock. Required: s,B = 0,0 / 1,1 / 1,0 / 0,0, settling within each interval.
- Reset check: hold rst_n=0 and toggle x,y. Required: s/B follow the truth table, while s_q=0, b_q=0, out_valid=0 and borrow_cnt=0 throughout.
- Registered path: after reset, set in_valid=1, x=0, y=1 for one edge. Required: the next cycle shows s_q=1, b_q=1, out_valid=1 and borrow_cnt=1. Then drop in_valid. Required: out_valid=0 while s_q/b_q hold.
- Counter saturation: CNT_W=2, in_valid=1, x=0, y=1 for 5 edges. Required: borrow_cnt sequence 1, 2, 3, 3, 3.
- Clear priority: borrow_cnt=2, assert cnt_clr with in_valid=1, x=0, y=1. Required: borrow_cnt=0 next cycle.
- Lane independence, WIDTH=4: x=4'b0101, y=4'b0011. Required: s=4'b0110, B=4'b0010.
- Async reset mid-run: deassert rst_n between clock edges. Required: all registered outputs clear immediately.
